// File: rtl/draw_sequencer.sv
// Frame draw sequencer: walks a list of drawing layers, pulses each drawer's
// start line, holds the pixel mux on that layer while it plots, and moves on
// when the drawer reports done or when the per-layer watchdog expires.
module draw_sequencer #(
    parameter int         TIMEOUT    = 20000,
    parameter logic [8:0] LAYER_MASK = 9'h0FF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       game_over,
    input  logic [8:0] done_bus,
    output logic [8:0] start_bus,
    output logic [4:0] pixel_sel,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    // Game-over frames draw only the background and the game-over banner.
    localparam logic [8:0]    GO_LIST = 9'h101;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DRAW,
        NEXT,
        FINISH
    } state_t;

    state_t          r_state, w_state_next;
    logic [3:0]      r_layer, w_layer_next;
    logic            r_go, w_go_next;
    logic [CW-1:0]   r_wdog, w_wdog_next;
    logic [8:0]      r_start_bus, w_start_next;
    logic            r_plot, w_plot_next;
    logic            r_busy, w_busy_next;
    logic            r_frame_done, w_frame_done_next;
    logic            r_overrun, w_overrun_next;
    logic            r_timeout, w_timeout_next;

    logic [8:0]      w_tick_list;   // list chosen by the frame being accepted
    logic [8:0]      w_run_list;    // list of the frame in progress
    logic [8:0]      w_sel_onehot;  // current layer as a one-hot mask
    logic [8:0]      w_above;       // layers strictly above the current one
    logic [8:0]      w_next_cand;
    logic            w_first_any, w_next_any;
    logic [3:0]      w_first_idx, w_next_idx;
    logic            w_done_hit;
    logic            w_wd_expired;

    assign w_tick_list = game_over ? GO_LIST : LAYER_MASK;
    assign w_run_list  = r_go ? GO_LIST : LAYER_MASK;

    // Per-layer decode of the current layer; only the selected drawer's done counts.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_layer_dec
            assign w_sel_onehot[gi] = (r_layer == 4'(gi));
            assign w_above[gi]      = (4'(gi) > r_layer);
        end
    endgenerate

    assign w_next_cand  = w_run_list & w_above;
    assign w_done_hit   = |(done_bus & w_sel_onehot);
    assign w_wd_expired = (r_wdog == WD_LAST);

    // Lowest set bit of the accepted list and of the remaining list.
    always_comb begin
        w_first_any = |w_tick_list;
        w_next_any  = |w_next_cand;
        w_first_idx = 4'd0;
        w_next_idx  = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (w_tick_list[i]) w_first_idx = 4'(i);
            if (w_next_cand[i]) w_next_idx  = 4'(i);
        end
    end

    // Next state plus the registered output values implied by that state.
    always_comb begin
        w_state_next   = r_state;
        w_layer_next   = r_layer;
        w_go_next      = r_go;
        w_overrun_next = r_overrun;
        w_timeout_next = r_timeout;

        case (r_state)
            IDLE: begin
                if (frame_tick) begin
                    w_go_next = game_over;
                    if (w_first_any) begin
                        w_state_next = START;
                        w_layer_next = w_first_idx;
                    end else begin
                        w_state_next = FINISH;
                    end
                end
            end
            START: w_state_next = DRAW;
            DRAW: begin
                if (w_done_hit) begin
                    w_state_next = NEXT;
                end else if (w_wd_expired) begin
                    w_state_next   = NEXT;
                    w_timeout_next = 1'b1;
                end
            end
            NEXT: begin
                if (w_next_any) begin
                    w_state_next = START;
                    w_layer_next = w_next_idx;
                end else begin
                    w_state_next = FINISH;
                end
            end
            FINISH:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        // Ticks that arrive mid-frame are dropped, not queued.
        if (frame_tick && r_busy) w_overrun_next = 1'b1;

        if (w_state_next == FINISH || w_state_next == IDLE) w_layer_next = 4'd0;

        w_start_next      = (w_state_next == START) ? (9'b1 << w_layer_next) : 9'h000;
        w_plot_next       = (w_state_next == DRAW);
        w_busy_next       = (w_state_next != IDLE);
        w_frame_done_next = (w_state_next == FINISH);
        // Watchdog reads 0 in the first DRAW cycle of each layer.
        w_wdog_next       = (w_state_next == DRAW && r_state == DRAW) ? r_wdog + 1'b1 : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_layer      <= 4'd0;
            r_go         <= 1'b0;
            r_wdog       <= '0;
            r_start_bus  <= 9'h000;
            r_plot       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_layer      <= w_layer_next;
            r_go         <= w_go_next;
            r_wdog       <= w_wdog_next;
            r_start_bus  <= w_start_next;
            r_plot       <= w_plot_next;
            r_busy       <= w_busy_next;
            r_frame_done <= w_frame_done_next;
            r_overrun    <= w_overrun_next;
            r_timeout    <= w_timeout_next;
        end
    end

    assign start_bus   = r_start_bus;
    assign pixel_sel   = {1'b0, r_layer};
    assign plot        = r_plot;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: a main instance (TIMEOUT=16, default
// mask) and an empty-mask instance driven by the same inputs.
module tb_draw_sequencer;

    logic       clk = 1'b0;
    logic       reset, frame_tick, game_over;
    logic [8:0] done_bus;
    logic [8:0] start_bus, start_bus_z;
    logic [4:0] pixel_sel, pixel_sel_z;
    logic       plot, busy, frame_done, overrun, timeout_err;
    logic       plot_z, busy_z, frame_done_z, overrun_z, timeout_err_z;

    int checks   = 0;
    int failures = 0;

    // Per-frame observations collected by run_frame.
    int         n_starts, n_fd, n_starts_z, n_fd_z, first_start_cyc;
    int         plot_cnt [9];
    logic [4:0] seq [16];
    logic [8:0] sb_seq [16];
    bit         budget_hit, onehot_bad, wrong_ok, post_busy_bad, z_bad;
    logic       fd_z_c1, busy_z_c2;
    logic [4:0] rst_pix;
    logic       rst_busy, rst_plot;

    always #5 clk = ~clk;

    draw_sequencer #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_over(game_over),
        .done_bus(done_bus), .start_bus(start_bus), .pixel_sel(pixel_sel), .plot(plot),
        .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
    );

    draw_sequencer #(.TIMEOUT(16), .LAYER_MASK(9'h000)) dut_z (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_over(game_over),
        .done_bus(done_bus), .start_bus(start_bus_z), .pixel_sel(pixel_sel_z), .plot(plot_z),
        .busy(busy_z), .frame_done(frame_done_z), .overrun(overrun_z), .timeout_err(timeout_err_z)
    );

    // Runs one frame with a drawer model (done in the 6th cycle after start)
    // and optional fault injections; layer arguments of -1 disable them.
    task automatic run_frame(input logic go, input int never_l, input int ovr_l,
                             input int rst_l, input int wrong_l);
        int cyc, done_at, cur, post, rst_phase;
        bit finished, wrong_pend, ovr_used, wrong_used;
        n_starts = 0; n_fd = 0; n_starts_z = 0; n_fd_z = 0; first_start_cyc = -1;
        for (int i = 0; i < 9; i++) plot_cnt[i] = 0;
        for (int i = 0; i < 16; i++) begin seq[i] = '1; sb_seq[i] = '0; end
        budget_hit = 0; onehot_bad = 0; wrong_ok = 0; post_busy_bad = 0; z_bad = 0;
        fd_z_c1 = 0; busy_z_c2 = 1; rst_pix = '1; rst_busy = 1; rst_plot = 1;
        finished = 0; wrong_pend = 0; ovr_used = 0; wrong_used = 0;
        done_at = -1; cur = 0; post = -1; rst_phase = 0;
        game_over = go; frame_tick = 1'b1; done_bus = 9'h000;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        game_over  = ~go;   // must not affect a frame already accepted
        cyc = 1;
        while (!finished) begin
            if (start_bus != 9'h000) begin
                if (n_starts < 16) begin seq[n_starts] = pixel_sel; sb_seq[n_starts] = start_bus; end
                if (n_starts == 0) first_start_cyc = cyc;
                if (start_bus != (9'b1 << pixel_sel)) onehot_bad = 1;
                n_starts++;
                cur = int'(pixel_sel);
                done_at = (cur == never_l) ? -1 : cyc + 6;
            end
            if (start_bus_z != 9'h000) n_starts_z++;
            if (frame_done_z) n_fd_z++;
            if (plot_z || pixel_sel_z != 5'd0) z_bad = 1;
            if (cyc == 1) fd_z_c1 = frame_done_z;
            if (cyc == 2) busy_z_c2 = busy_z;
            if (plot && pixel_sel < 5'd9) plot_cnt[pixel_sel]++;
            if (frame_done) begin
                n_fd++; post = 0;
            end else if (post >= 0) begin
                post++;
                if (busy) post_busy_bad = 1;
            end
            if (wrong_pend) begin
                wrong_ok = plot && (int'(pixel_sel) == wrong_l) && busy;
                wrong_pend = 0;
            end
            if (rst_phase == 1) begin
                rst_pix = pixel_sel; rst_busy = busy; rst_plot = plot;
                reset = 1'b0; rst_phase = 2; post = 0;
            end
            frame_tick = 1'b0;
            done_bus = (cyc == done_at) ? (9'b1 << cur) : 9'h000;
            if (ovr_l >= 0 && !ovr_used && plot && int'(pixel_sel) == ovr_l) begin
                frame_tick = 1'b1; ovr_used = 1;
            end
            if (wrong_l >= 0 && !wrong_used && plot && int'(pixel_sel) == wrong_l &&
                plot_cnt[wrong_l] == 2) begin
                done_bus = 9'h020; wrong_used = 1; wrong_pend = 1;
            end
            if (rst_l >= 0 && rst_phase == 0 && plot && int'(pixel_sel) == rst_l &&
                plot_cnt[rst_l] == 2) begin
                reset = 1'b1; rst_phase = 1;
            end
            if (post >= 4) finished = 1;
            if (cyc >= 600) begin budget_hit = 1; finished = 1; end
            @(posedge clk); #1;
            cyc++;
        end
        done_bus = 9'h000; frame_tick = 1'b0; game_over = 1'b0;
        $display("frame go=%0d starts=%0d frame_done=%0d cycles=%0d", go, n_starts, n_fd, cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_tick = 1'b1; game_over = 1'b0; done_bus = 9'h000;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        checks++; if (start_bus !== 9'h000) begin failures++; $display("FAIL reset_start got=%h exp=000", start_bus); end
        checks++; if (pixel_sel !== 5'd0) begin failures++; $display("FAIL reset_pixsel got=%0d exp=0", pixel_sel); end
        checks++; if ({plot, busy, frame_done} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {plot, busy, frame_done}); end
        checks++; if ({overrun, timeout_err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {overrun, timeout_err}); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_tick_ignored busy got=%b exp=0", busy); end
        $display("reset done");
    endtask

    task automatic test_empty_mask();
        run_frame(1'b0, -1, -1, -1, -1);
        checks++; if (n_starts_z !== 0) begin failures++; $display("FAIL empty_starts got=%0d exp=0", n_starts_z); end
        checks++; if (n_fd_z !== 1) begin failures++; $display("FAIL empty_frame_done got=%0d exp=1", n_fd_z); end
        checks++; if (fd_z_c1 !== 1'b1) begin failures++; $display("FAIL empty_direct_finish got=%b exp=1", fd_z_c1); end
        checks++; if (busy_z_c2 !== 1'b0) begin failures++; $display("FAIL empty_idle got=%b exp=0", busy_z_c2); end
        checks++; if ({z_bad, overrun_z, timeout_err_z} !== 3'b000) begin failures++; $display("FAIL empty_misc got=%b exp=000", {z_bad, overrun_z, timeout_err_z}); end
    endtask

    task automatic test_play_frame();
        run_frame(1'b0, -1, -1, -1, -1);
        checks++; if (budget_hit !== 1'b0) begin failures++; $display("FAIL play_budget expired"); end
        checks++; if (first_start_cyc !== 1) begin failures++; $display("FAIL play_latency got=%0d exp=1", first_start_cyc); end
        checks++; if (n_starts !== 8) begin failures++; $display("FAIL play_starts got=%0d exp=8", n_starts); end
        checks++; if (onehot_bad !== 1'b0) begin failures++; $display("FAIL play_onehot start_bus not matching pixel_sel"); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (seq[i] !== 5'(i)) begin failures++; $display("FAIL play_seq[%0d] got=%0d exp=%0d", i, seq[i], i); end
            checks++; if (plot_cnt[i] !== 6) begin failures++; $display("FAIL play_plot[%0d] got=%0d exp=6", i, plot_cnt[i]); end
        end
        checks++; if (plot_cnt[8] !== 0) begin failures++; $display("FAIL play_plot8 got=%0d exp=0", plot_cnt[8]); end
        checks++; if (n_fd !== 1) begin failures++; $display("FAIL play_frame_done got=%0d exp=1", n_fd); end
        checks++; if (post_busy_bad !== 1'b0) begin failures++; $display("FAIL play_idle_after busy seen"); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL play_timeout got=%b exp=0", timeout_err); end
    endtask

    task automatic test_game_over();
        run_frame(1'b1, -1, -1, -1, -1);
        checks++; if (n_starts !== 2) begin failures++; $display("FAIL go_starts got=%0d exp=2", n_starts); end
        checks++; if (sb_seq[0] !== 9'h001) begin failures++; $display("FAIL go_start0 got=%h exp=001", sb_seq[0]); end
        checks++; if (sb_seq[1] !== 9'h100) begin failures++; $display("FAIL go_start1 got=%h exp=100", sb_seq[1]); end
        checks++; if (seq[1] !== 5'd8) begin failures++; $display("FAIL go_pixsel1 got=%0d exp=8", seq[1]); end
        checks++; if (plot_cnt[8] !== 6) begin failures++; $display("FAIL go_plot8 got=%0d exp=6", plot_cnt[8]); end
        checks++; if (n_fd !== 1) begin failures++; $display("FAIL go_frame_done got=%0d exp=1", n_fd); end
    endtask

    task automatic test_wrong_layer();
        run_frame(1'b0, -1, -1, -1, 2);
        checks++; if (wrong_ok !== 1'b1) begin failures++; $display("FAIL wrong_done_ignored got=%b exp=1", wrong_ok); end
        checks++; if (plot_cnt[2] !== 6) begin failures++; $display("FAIL wrong_plot2 got=%0d exp=6", plot_cnt[2]); end
        checks++; if (n_starts !== 8) begin failures++; $display("FAIL wrong_starts got=%0d exp=8", n_starts); end
    endtask

    task automatic test_timeout();
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_pre got=%b exp=0", timeout_err); end
        run_frame(1'b0, 3, -1, -1, -1);
        checks++; if (plot_cnt[3] !== 16) begin failures++; $display("FAIL timeout_len got=%0d exp=16", plot_cnt[3]); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b exp=1", timeout_err); end
        checks++; if (n_starts !== 8) begin failures++; $display("FAIL timeout_starts got=%0d exp=8", n_starts); end
        for (int i = 4; i < 8; i++) begin
            checks++; if (plot_cnt[i] !== 6) begin failures++; $display("FAIL timeout_plot[%0d] got=%0d exp=6", i, plot_cnt[i]); end
        end
        checks++; if (n_fd !== 1) begin failures++; $display("FAIL timeout_frame_done got=%0d exp=1", n_fd); end
    endtask

    task automatic test_sticky();
        run_frame(1'b0, -1, -1, -1, -1);
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL sticky_timeout got=%b exp=1", timeout_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL sticky_overrun_pre got=%b exp=0", overrun); end
    endtask

    task automatic test_overrun();
        run_frame(1'b0, -1, 2, -1, -1);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
        checks++; if (n_fd !== 1) begin failures++; $display("FAIL overrun_frame_done got=%0d exp=1", n_fd); end
        checks++; if (n_starts !== 8) begin failures++; $display("FAIL overrun_starts got=%0d exp=8", n_starts); end
        checks++; if (post_busy_bad !== 1'b0) begin failures++; $display("FAIL overrun_no_second_frame busy seen"); end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(1'b0, -1, -1, 4, -1);
        checks++; if (rst_pix !== 5'd0) begin failures++; $display("FAIL midrst_pixsel got=%0d exp=0", rst_pix); end
        checks++; if ({rst_busy, rst_plot} !== 2'b00) begin failures++; $display("FAIL midrst_ctl got=%b exp=00", {rst_busy, rst_plot}); end
        checks++; if (n_fd !== 0) begin failures++; $display("FAIL midrst_frame_done got=%0d exp=0", n_fd); end
        checks++; if (post_busy_bad !== 1'b0) begin failures++; $display("FAIL midrst_idle busy seen"); end
        checks++; if ({overrun, timeout_err} !== 2'b00) begin failures++; $display("FAIL midrst_flags got=%b exp=00", {overrun, timeout_err}); end
        run_frame(1'b0, -1, -1, -1, -1);
        checks++; if (seq[0] !== 5'd0) begin failures++; $display("FAIL midrst_restart got=%0d exp=0", seq[0]); end
        checks++; if (n_starts !== 8) begin failures++; $display("FAIL midrst_restart_starts got=%0d exp=8", n_starts); end
        checks++; if (n_fd !== 1) begin failures++; $display("FAIL midrst_restart_done got=%0d exp=1", n_fd); end
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; game_over = 1'b0; done_bus = 9'h000;
        test_reset();
        test_empty_mask();
        test_play_frame();
        test_game_over();
        test_wrong_layer();
        test_timeout();
        test_sticky();
        test_overrun();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
